pool1_seq: RTL and testbench

- Sequencer for the 2x2 max-pool datapath `pool1`, which has a 512x32 row buffer.
- Accepts a raster-order pixel stream with valid/ready. Each 32-bit word is one pixel carrying two signed 16-bit channels.
- Generates the pool datapath controls `v`, `dtype` and `ar` from column/row counters.
- Registers the pooled results into an output stream with backpressure, and reports frame completion.

---
 rtl/pool1_pkg.sv | 25 ++
 rtl/pool1_seq_cnt.sv | 59 +++++
 rtl/pool1_seq.sv | 186 ++++++++++++++++++
 tb/tb_pool1_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool1_pkg.sv
// pool1_pkg: shared types and constants for the pool1 max-pool sequencer.
package pool1_pkg;

    localparam int unsigned COL_W  = 10;
    localparam int unsigned ROW_W  = 10;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Datapath dtype encodings: bit0 = column parity, bit1 = row parity
    localparam logic [1:0] DT_C0R0 = 2'b00;
    localparam logic [1:0] DT_C1R0 = 2'b01;
    localparam logic [1:0] DT_C0R1 = 2'b10;
    localparam logic [1:0] DT_C1R1 = 2'b11;

    // A frame dimension is usable only if it is non-zero and even
    function automatic logic dim_ok(input logic [15:0] v);
        return (v != 16'd0) && !v[0];
    endfunction

endpackage

// File: rtl/pool1_seq_cnt.sv
// pool1_seq_cnt: raster column/row counter with a last-pixel-of-frame flag.
module pool1_seq_cnt
    import pool1_pkg::*;
#(
    parameter int unsigned COL_W = pool1_pkg::COL_W,
    parameter int unsigned ROW_W = pool1_pkg::ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic [COL_W-1:0] cols_m1,
    input  logic [ROW_W-1:0] rows_m1,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_eol;

    assign col_eol = (col_q == cols_m1);
    assign last    = col_eol && (row_q == rows_m1);
    assign col     = col_q;
    assign row     = row_q;

    // Next counter position: clear on frame start, step on each accepted pixel
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (adv) begin
            if (last) begin
                col_d = '0;
                row_d = '0;
            end else if (col_eol) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/pool1_seq.sv
// pool1_seq: sequencer for the pool1 2x2 max-pool datapath.
// Optional build macro POOL1_SEQ_PERF_EN adds stall_cnt/beat_cnt counters.
module pool1_seq
    import pool1_pkg::*;
#(
    parameter int unsigned COL_W  = pool1_pkg::COL_W,
    parameter int unsigned ROW_W  = pool1_pkg::ROW_W,
    parameter int unsigned DATA_W = pool1_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COL_W:0]    cfg_cols,
    input  logic [ROW_W:0]    cfg_rows,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              pv,
    output logic [DATA_W-1:0] pdata,
    output logic [1:0]        pdtype,
    output logic [COL_W-1:0]  par,
    input  logic              pd_valid,
    input  logic [DATA_W-1:0] pans,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
`ifdef POOL1_SEQ_PERF_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       beat_cnt,
`endif
    output logic              cfg_err
);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  cols_m1_q, cols_m1_d;
    logic [ROW_W-1:0]  rows_m1_q, rows_m1_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              accept;
    logic              cfg_good;
    logic              start_ok;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              last_px;

    assign cfg_good = dim_ok(16'(cfg_cols)) && dim_ok(16'(cfg_rows));
    assign start_ok = start && (state_q == IDLE) && cfg_good;

    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign pv     = accept;
    assign pdata  = in_data;
    assign pdtype = {row[0], col[0]};
    assign par    = col;

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

    pool1_seq_cnt #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .adv     (accept),
        .cols_m1 (cols_m1_q),
        .rows_m1 (rows_m1_q),
        .col     (col),
        .row     (row),
        .last    (last_px)
    );

    // Frame FSM, config latch and output register next-state
    always_comb begin
        state_d     = state_q;
        cols_m1_d   = cols_m1_q;
        rows_m1_d   = rows_m1_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_good) begin
                        cols_m1_d = COL_W'(cfg_cols - (COL_W+1)'(1));
                        rows_m1_d = ROW_W'(cfg_rows - (ROW_W+1)'(1));
                        state_d   = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept && last_px) state_d = DONE;
            end
            DONE: begin
                if (!out_valid_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pd_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = pans;
            out_last_d  = accept && last_px;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cols_m1_q   <= '0;
            rows_m1_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_m1_q   <= cols_m1_d;
            rows_m1_q   <= rows_m1_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef POOL1_SEQ_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;

    assign stall_cnt = stall_cnt_q;
    assign beat_cnt  = beat_cnt_q;

    // Stall and beat counters, cleared by an accepted start
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (start_ok) begin
            stall_cnt_d = '0;
            beat_cnt_d  = '0;
        end else begin
            if ((state_q == RUN) && in_valid && !in_ready) stall_cnt_d = stall_cnt_q + 32'd1;
            if (accept) beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pool1_seq.sv
// tb_pool1_seq: directed bench for pool1_seq with a behavioural pool1 datapath.
module tb_pool1_seq;
    import pool1_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] cfg_cols;
    logic [10:0] cfg_rows;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        pv;
    logic [31:0] pdata;
    logic [1:0]  pdtype;
    logic [9:0]  par;
    logic        pd_valid;
    logic [31:0] pans;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        cfg_err;
`ifdef POOL1_SEQ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] beat_cnt;
`endif

    pool1_seq #(
        .COL_W  (10),
        .ROW_W  (10),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_cols  (cfg_cols),
        .cfg_rows  (cfg_rows),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pv        (pv),
        .pdata     (pdata),
        .pdtype    (pdtype),
        .par       (par),
        .pd_valid  (pd_valid),
        .pans      (pans),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
`ifdef POOL1_SEQ_PERF_EN
        .stall_cnt (stall_cnt),
        .beat_cnt  (beat_cnt),
`endif
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural pool1 datapath ----------------
    logic [31:0] hold_q;
    logic [31:0] rowbuf [512];

    function automatic logic [31:0] pmax(input logic [31:0] a, input logic [31:0] b);
        logic signed [15:0] a0, a1, b0, b1;
        a0 = a[31:16]; a1 = a[15:0];
        b0 = b[31:16]; b1 = b[15:0];
        return {(a0 > b0) ? a0 : b0, (a1 > b1) ? a1 : b1};
    endfunction

    always_comb begin
        pd_valid = pv && (pdtype == DT_C1R1);
        pans     = pmax(rowbuf[par[9:1]], pmax(hold_q, pdata));
    end

    always @(posedge clk) begin
        if (pv) begin
            if (pdtype == DT_C0R0 || pdtype == DT_C0R1) hold_q <= pdata;
            else if (pdtype == DT_C1R0) rowbuf[par[9:1]] <= pmax(hold_q, pdata);
        end
    end

    // ---------------- output / done monitor ----------------
    int          cyc;
    int          done_cnt;
    int          done_cyc;
    int          last_pop_cyc;
    logic [31:0] q_data [$];
    logic        q_last [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            if (out_last) last_pop_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // ---------------- check helpers ----------------
    int n_pass;
    int n_tot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] acc_dt;
    logic [9:0] acc_ar;

    task automatic start_frame(input logic [10:0] c, input logic [10:0] r);
        cfg_cols = c;
        cfg_rows = r;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Present one pixel and return just after the edge that accepts it
    task automatic send(input logic [31:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
        acc_dt = pdtype;
        acc_ar = par;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, done_cnt, d0 + 1);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic l);
        if (q_data.size() > 0) begin
            chk(tag, q_data.pop_front(), d);
            chk({tag, "_last"}, 32'(q_last.pop_front()), 32'(l));
        end else begin
            chk({tag, "_missing"}, q_data.size(), 1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int v;
        int d0;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_cols  = '0;
        cfg_rows  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        n_pass    = 0;
        n_tot     = 0;
        done_cnt  = 0;
        done_cyc  = 0;
        last_pop_cyc = 0;

        // Reset state
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_pv", 32'(pv), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_pdtype", 32'(pdtype), 0);
        chk("rst_par", 32'(par), 0);
        rst = 1'b0;
        tick();

        // 4x2 frame, pixels 1..8 in both channels
        start_frame(11'd4, 11'd2);
        chk("t1_busy", 32'(busy), 1);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = r * 4 + c + 1;
                send({16'(v), 16'(v)});
                chk("t1_pdtype", 32'(acc_dt), 32'({r[0], c[0]}));
                chk("t1_par", 32'(acc_ar), 32'(c));
            end
        end
        chk("t1_last_flag", 32'(out_last), 1);
        d0 = done_cnt;
        wait_done("t1_done");
        chk("t1_nout", q_data.size(), 2);
        expect_out("t1_out0", 32'h0006_0006, 1'b0);
        expect_out("t1_out1", 32'h0008_0008, 1'b1);
        chk("t1_done_lat", 32'(done_cyc - last_pop_cyc), 2);
        tick();
        tick();
        chk("t1_done_once", done_cnt, d0 + 1);
        chk("t1_idle", 32'(busy), 0);

        // 2x2 frame of negative values
        q_data.delete(); q_last.delete();
        start_frame(11'd2, 11'd2);
        send(32'hFFFB_FFFB);
        send(32'hFFFD_FFFD);
        send(32'hFFF9_FFF9);
        send(32'hFFFE_FFFE);
        wait_done("t2_done");
        chk("t2_nout", q_data.size(), 1);
        expect_out("t2_out", 32'hFFFE_FFFE, 1'b1);

        // 4x4 frame with 5 cycles of downstream backpressure
        q_data.delete(); q_last.delete();
        start_frame(11'd4, 11'd4);
        for (int i = 0; i < 6; i++) send({16'(i + 1), 16'(i + 1)});
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0007_0007;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_in_ready", 32'(in_ready), 0);
            chk("t3_stall_out_valid", 32'(out_valid), 1);
            chk("t3_stall_out_data", out_data, 32'h0006_0006);
            chk("t3_stall_par", 32'(par), 2);
            tick();
        end
        chk("t3_no_pop", q_data.size(), 0);
        out_ready = 1'b1;
        for (int i = 6; i < 16; i++) send({16'(i + 1), 16'(i + 1)});
        wait_done("t3_done");
        chk("t3_nout", q_data.size(), 4);
        expect_out("t3_out0", 32'h0006_0006, 1'b0);
        expect_out("t3_out1", 32'h0008_0008, 1'b0);
        expect_out("t3_out2", 32'h000E_000E, 1'b0);
        expect_out("t3_out3", 32'h0010_0010, 1'b1);

        // Rejected configurations, then a good 2x2 frame with a stray start
        q_data.delete(); q_last.delete();
        start_frame(11'd3, 11'd2);
        chk("t4_cfg_err_odd", 32'(cfg_err), 1);
        chk("t4_busy_odd", 32'(busy), 0);
        tick();
        chk("t4_cfg_err_pulse", 32'(cfg_err), 0);
        start_frame(11'd2, 11'd0);
        chk("t4_cfg_err_zero", 32'(cfg_err), 1);
        chk("t4_busy_zero", 32'(busy), 0);
        start_frame(11'd2, 11'd2);
        chk("t4_busy_good", 32'(busy), 1);
        chk("t4_no_err_good", 32'(cfg_err), 0);
        send({16'd1, 16'd100});
        start_frame(11'd4, 11'd4);
        chk("t4_run_start_no_err", 32'(cfg_err), 0);
        send({16'd2, 16'd50});
        send({16'd3, 16'd25});
        send({16'd4, 16'd12});
        wait_done("t4_done");
        chk("t4_nout", q_data.size(), 1);
        expect_out("t4_out", 32'h0004_0064, 1'b1);

        // Reset mid-way through an 8x8 frame
        q_data.delete(); q_last.delete();
        start_frame(11'd8, 11'd8);
        for (int i = 0; i < 10; i++) send({16'(i + 1), 16'(i + 1)});
        chk("t5_pre_out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_in_ready", 32'(in_ready), 0);
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_par", 32'(par), 0);
        chk("t5_pdtype", 32'(pdtype), 0);
        tick();
        rst = 1'b0;
        tick();
        q_data.delete(); q_last.delete();
        start_frame(11'd2, 11'd2);
        send({16'd9, 16'd1});
        send({16'd3, 16'd8});
        send({16'd5, 16'd2});
        send({16'd7, 16'd4});
        wait_done("t5_done");
        chk("t5_nout", q_data.size(), 1);
        expect_out("t5_out", 32'h0009_0008, 1'b1);

`ifdef POOL1_SEQ_PERF_EN
        // 4x2 frame with one input gap and 3 backpressure cycles
        q_data.delete(); q_last.delete();
        start_frame(11'd4, 11'd2);
        chk("t6_beat_clr", beat_cnt, 0);
        chk("t6_stall_clr", stall_cnt, 0);
        send(32'h0001_0001);
        send(32'h0002_0002);
        tick();
        for (int i = 2; i < 6; i++) send({16'(i + 1), 16'(i + 1)});
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0007_0007;
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        send(32'h0007_0007);
        send(32'h0008_0008);
        wait_done("t6_done");
        chk("t6_beat_cnt", beat_cnt, 8);
        chk("t6_stall_cnt", stall_cnt, 3);
        chk("t6_nout", q_data.size(), 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
